// File: rtl/mips_pkg.sv
// Shared types, constants and address arithmetic for the MIPS program-counter path.
package mips_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam addr_t HALT_ADDR_DEFAULT = 32'h0000_0000;

  // Word-scaled, sign-extended offset relative to the delay-slot address; wraps mod 2^32.
  function automatic addr_t branch_target(input addr_t pc, input logic [15:0] imm16, input addr_t inc);
    addr_t offset;
    offset = {{14{imm16[15]}}, imm16, 2'b00};
    return pc + inc + offset;
  endfunction

  function automatic addr_t jump_target(input addr_t pc_plus4, input logic [25:0] index26);
    return {pc_plus4[31:28], index26, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect priority mux (JR/JALR > J/JAL > branch) and target arithmetic.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inc,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic        redirect,
  output logic [31:0] target
);

  addr_t pc_plus4;

  assign pc_plus4 = pc + inc;

  // Select the highest-priority redirect source and its target address.
  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    if (jump_reg) begin
      redirect = 1'b1;
      target   = reg_target;
    end else if (jump) begin
      redirect = 1'b1;
      target   = jump_target(pc_plus4, jump_index);
    end else if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_target(pc, branch_imm, inc);
    end else begin
      redirect = 1'b0;
      target   = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC with branch-delay-slot sequencing and halt-on-jump-to-HALT_ADDR detection.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_reset_vector,
  input  logic [31:0] in_const_4,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        target_misaligned
);

  pc_state_t state;
  pc_state_t state_next;
  addr_t     pending_target;
  addr_t     pending_next;
  addr_t     pc_next;
  logic      delay_next;
  logic      active_next;
  logic      misaligned_next;
  logic      redirect;
  addr_t     target;

  pc_target_calc u_calc (
    .pc           (pc),
    .inc          (in_const_4),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .redirect     (redirect),
    .target       (target)
  );

  assign link_addr = pc + 32'd8;

  // Next-state and next-register computation; everything holds unless an instruction retires.
  always_comb begin
    state_next      = state;
    pending_next    = pending_target;
    pc_next         = pc;
    delay_next      = in_delay_slot;
    active_next     = active;
    misaligned_next = target_misaligned;
    case (state)
      RUN: begin
        if (advance) begin
          pc_next = pc + in_const_4;
          if (redirect) begin
            pending_next = target;
            state_next   = DELAY;
            delay_next   = 1'b1;
            if (target[1:0] != 2'b00) begin
              misaligned_next = 1'b1;
            end else begin
              misaligned_next = target_misaligned;
            end
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      DELAY: begin
        // Redirects retiring from the delay slot itself are deliberately dropped.
        if (advance) begin
          pc_next    = pending_target;
          delay_next = 1'b0;
          if (pending_target == HALT_ADDR) begin
            state_next  = HALTED;
            active_next = 1'b0;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = DELAY;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next  = HALTED;
        active_next = 1'b0;
        delay_next  = 1'b0;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      pc                <= in_reset_vector;
      pending_target    <= 32'h0000_0000;
      in_delay_slot     <= 1'b0;
      active            <= 1'b1;
      target_misaligned <= 1'b0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      pending_target    <= pending_next;
      in_delay_slot     <= delay_next;
      active            <= active_next;
      target_misaligned <= misaligned_next;
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the constant-register block. Consumes its registered reset vector and increment constant.
- Holds the architectural PC for the multicycle MIPS core and implements branch-delay-slot semantics for branches, J/JAL and JR/JALR.
- Detects the halt condition, which is a jump to address 0x00000000.
- Drives the fetch address and the link address.

Parameters:
- HALT_ADDR, 32'h00000000, target address that ends execution

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- in_reset_vector  input  32  reset vector from constant block (0xBFC00000)
- in_const_4  input  32  increment constant from constant block (4)
- advance  input  1  one instruction retires this cycle; PC steps
- branch_taken  input  1  retiring instruction is a taken conditional branch
- branch_imm  input  16  branch immediate field
- jump  input  1  retiring instruction is J/JAL
- jump_index  input  26  instr_index field
- jump_reg  input  1  retiring instruction is JR/JALR
- reg_target  input  32  rs value for JR/JALR
- pc  output  32  current fetch address (registered)
- link_addr  output  32  pc + 8 (combinational from pc, for JAL/JALR/BGEZAL)
- in_delay_slot  output  1  the instruction at pc is a delay slot
- active  output  1  CPU running; 0 once halted
- target_misaligned  output  1  pending target has bits [1:0] != 0 (sticky until reset)

Behaviour:
- Reset:
  - Every cycle reset=1: pc <= in_reset_vector, state <= RUN, pending_target <= 0, in_delay_slot <= 0, active <= 1, target_misaligned <= 0.
  - Reset must be held for at least 2 cycles, because the constant block's outputs are registered and are invalid in the first cycle.
  - Reset asserted mid-operation overrides everything, including a pending DELAY.
- States: RUN, DELAY, HALTED. Nothing changes while advance=0.
- RUN with advance=1:
  - Redirect request: jump_reg, jump or branch_taken. Priority is jump_reg > jump > branch.
  - Branch target = pc + in_const_4 + (sign_extend(branch_imm) << 2). Arithmetic is 32-bit modulo, so it wraps.
  - Jump target = {(pc + in_const_4)[31:28], jump_index, 2'b00}.
  - JR target = reg_target, used unmodified.
  - If any request is present: pending_target <= target; pc <= pc + in_const_4; state <= DELAY; in_delay_slot <= 1.
  - If target[1:0] != 0: target_misaligned <= 1, and the target is still taken.
  - No request: pc <= pc + in_const_4.
- DELAY with advance=1:
  - pc <= pending_target; in_delay_slot <= 0.
  - If pending_target == HALT_ADDR: state <= HALTED, active <= 0, and pc still loads HALT_ADDR.
  - Otherwise state <= RUN.
  - Redirect requests in DELAY (a branch in a delay slot) are ignored.
- HALTED: pc, active and pending_target are frozen; all inputs are ignored until reset.
- A jump to HALT_ADDR still executes its delay slot before halting.
- Increment at 0xFFFFFFFC wraps to 0x00000000. This wrap is not a halt; a halt happens only via a redirect target.
- Latency: the new pc is visible the cycle after the advance edge. link_addr tracks pc combinationally.

Decomposition:
- Shared package mips_pkg holds:
  - typedef addr_t (logic [31:0])
  - enum pc_state_t {RUN, DELAY, HALTED}
  - constant HALT_ADDR default
  - function branch_target(pc, imm16, inc)
  - function jump_target(pc_plus4, index26)
- One sub-module is natural: pc_target_calc, a combinational priority mux plus target arithmetic. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset sequence: reset held 3 cycles with the constant block running, then advance=1 for 3 cycles -> pc = 0xBFC00000, then 0xBFC00004, 0xBFC00008. active=1, link_addr = pc+8.
- Taken branch: pc=0xBFC00010, branch_taken=1, imm=0xFFFC (-4) -> next pc 0xBFC00014 with in_delay_slot=1, then pc 0xBFC00004.
- J/JR priority: pc=0xBFC00020, jump=1 with index=0x0000100 and jump_reg=1 with reg_target=0xBFC00400 -> delay slot 0xBFC00024, then 0xBFC00400.
- Halt: jump_reg=1, reg_target=0 at pc=0xBFC00030 -> pc=0xBFC00034, then pc=0x00000000 with active=0. Further advance/branch pulses leave pc=0 and active=0.
- Stall and delay-slot ignore: in DELAY hold advance=0 for 5 cycles -> pc unchanged. Then advance=1 with branch_taken=1 -> pending target taken and the new branch ignored.
- Reset mid-DELAY: assert reset for 2 cycles while in_delay_slot=1 -> pc=0xBFC00000, in_delay_slot=0, pending target discarded. Separately, JR to 0xBFC00402 -> target_misaligned=1 until reset.
